// File: rtl/button_bank.sv
// button_bank: N independent debounced push-button channels with
// one-cycle press/release pulses, a held level and a lowest-index
// press encoder for the game FSM.
// Optional auto-repeat on held buttons: define BUTTON_BANK_REPEAT_EN.
// The release pulse port is named release_pulse because "release"
// is a reserved word in SystemVerilog.

module button_bank_chan #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_PERIOD   = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press,
    output logic rel,
    output logic held
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   s;
    logic                   flip;
    logic                   rpt_fire;

    assign s    = sync_q[SYNC_STAGES-1];
    assign flip = (s != held) && (cnt == CNT_MAX);

    // Metastability synchroniser on the raw pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end

    // Stability counter, debounced level and registered edge pulses;
    // an accepted edge always wins over a due repeat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            held  <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            press <= flip ? s : rpt_fire;
            rel   <= flip & ~s;
            if (flip) begin
                held <= s;
                cnt  <= '0;
            end else if (s == held) begin
                cnt  <= '0;
            end else begin
                cnt  <= cnt + 1'b1;
            end
        end
    end

`ifdef BUTTON_BANK_REPEAT_EN
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PER_LAST = TMR_W'(REPEAT_PERIOD - 1);

    logic [TMR_W-1:0] tmr;
    logic             rpt_ph;   // 0: waiting initial delay, 1: periodic

    assign rpt_fire = held && !flip && (rpt_ph ? (tmr == PER_LAST) : (tmr == DLY_LAST));

    // Hold timer: restarts on every accepted edge, then after each repeat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr    <= '0;
            rpt_ph <= 1'b0;
        end else if (flip) begin
            tmr    <= '0;
            rpt_ph <= 1'b0;
        end else if (held) begin
            if (rpt_fire) begin
                tmr    <= '0;
                rpt_ph <= 1'b1;
            end else begin
                tmr    <= tmr + 1'b1;
            end
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif
endmodule

module button_bank #(
    parameter int N_BUTTONS       = 9,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_PERIOD   = 10,
    localparam int IDX_W          = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_BUTTONS-1:0] raw_button,
    output logic [N_BUTTONS-1:0] press,
    output logic [N_BUTTONS-1:0] release_pulse,
    output logic [N_BUTTONS-1:0] held,
    output logic                 any_press,
    output logic [IDX_W-1:0]     press_idx
);
    // Reject illegal configurations at elaboration
    if (N_BUTTONS < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("button_bank: illegal parameter value");
    end

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
        button_bank_chan #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw_button[i]),
            .press (press[i]),
            .rel   (release_pulse[i]),
            .held  (held[i])
        );
    end

    assign any_press = |press;

    // Lowest-index press wins; scan downward so the last hit is the lowest
    always_comb begin
        press_idx = '0;
        for (int i = N_BUTTONS - 1; i >= 0; i--) begin
            if (press[i]) press_idx = IDX_W'(i);
        end
    end
endmodule

// File: tb/tb_button_bank.sv
// Bench for button_bank: spec-level model checked every cycle, plus
// pinned literal expectations for the documented scenarios.
module tb_button_bank;
    localparam int N    = 9;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
`ifdef BUTTON_BANK_REPEAT_EN
    localparam int RD   = 50;
    localparam int RP   = 10;
    localparam logic RPT = 1'b1;
`else
    localparam logic RPT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] raw_button = '0;
    logic [N-1:0] press, release_pulse, held;
    logic         any_press;
    logic [3:0]   press_idx;

    logic raw1 = 1'b0;
    logic press1, rel1, held1, any1;
    logic [0:0] idx1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    button_bank u_dut (
        .clk(clk), .rst_n(rst_n), .raw_button(raw_button), .press(press),
        .release_pulse(release_pulse), .held(held), .any_press(any_press),
        .press_idx(press_idx)
    );

    button_bank #(.N_BUTTONS(1), .DEBOUNCE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .raw_button(raw1), .press(press1),
        .release_pulse(rel1), .held(held1), .any_press(any1),
        .press_idx(idx1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: s seen at an edge is raw sampled SYNC edges earlier; a level
    // change is accepted after DEB consecutive edges that disagree.
    logic [N-1:0]    m_press = '0, m_rel = '0, m_held = '0;
    logic [SYNC-1:0] hist [N];
    int              run [N];
    int              age [N];
    logic [3:0]      m_idx;

    initial begin
        for (int i = 0; i < N; i++) begin hist[i] = '0; run[i] = 0; age[i] = 0; end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_press = '0; m_rel = '0; m_held = '0;
                for (int i = 0; i < N; i++) begin hist[i] = '0; run[i] = 0; age[i] = 0; end
            end else begin
                for (int i = 0; i < N; i++) begin
                    logic s_b, flipped;
                    s_b = hist[i][SYNC-1];
                    m_press[i] = 1'b0; m_rel[i] = 1'b0; flipped = 1'b0;
                    if (s_b != m_held[i]) begin
                        run[i]++;
                        if (run[i] == DEB) begin
                            run[i] = 0; m_held[i] = s_b; flipped = 1'b1;
                            m_press[i] = s_b; m_rel[i] = !s_b; age[i] = 0;
                        end
                    end else run[i] = 0;
                    if (!flipped && m_held[i]) begin
                        age[i]++;
`ifdef BUTTON_BANK_REPEAT_EN
                        if (age[i] == RD || (age[i] > RD && (age[i] - RD) % RP == 0))
                            m_press[i] = 1'b1;
`endif
                    end
                    hist[i] = {hist[i][SYNC-2:0], raw_button[i]};
                end
            end
            m_idx = '0;
            for (int i = N - 1; i >= 0; i--) if (m_press[i]) m_idx = 4'(i);
        end
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(posedge clk);
        #1;
        chk("press", 32'(press), 32'(m_press));
        chk("release", 32'(release_pulse), 32'(m_rel));
        chk("held", 32'(held), 32'(m_held));
        chk("any_press", 32'(any_press), 32'(|m_press));
        chk("press_idx", 32'(press_idx), 32'(m_idx));
    end

    task automatic at_edge(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        // reset state
        at_edge(3);
        chk("rst_held", 32'(held), 0);
        chk("rst_press", 32'(press), 0);
        @(negedge clk) rst_n = 1'b1;
        at_edge(2);

        // single step on channel 3: press 5 edges after first sample
        raw_button[3] = 1'b1;
        at_edge(1);
        at_edge(4);
        chk("t1_early", 32'(press), 0);
        at_edge(1);
        chk("t1_press", 32'(press), 32'h008);
        chk("t1_any", 32'(any_press), 1);
        chk("t1_idx", 32'(press_idx), 3);
        at_edge(1);
        chk("t1_once", 32'(press), 0);
        chk("t1_held", 32'(held[3]), 1);
        raw_button[3] = 1'b0;
        at_edge(10);

        // short pulse filtered, then bounce accepted once
        raw_button[0] = 1'b1;
        at_edge(2);
        raw_button[0] = 1'b0;
        at_edge(8);
        chk("t2_short_held", 32'(held[0]), 0);
        begin
            logic [5:0] seq;
            seq = 6'b111101;  // applied LSB first: 1,0,1,1,1,1
            for (int b = 0; b < 6; b++) begin
                raw_button[0] = seq[b];
                at_edge(1);
            end
        end
        chk("t2_b4", 32'(press[0]), 0);
        at_edge(1);
        chk("t2_b5", 32'(press[0]), 0);
        at_edge(1);
        chk("t2_press", 32'(press[0]), 1);
        raw_button[0] = 1'b0;
        at_edge(10);

        // simultaneous presses on 2 and 7, then release 7 alone
        raw_button[2] = 1'b1; raw_button[7] = 1'b1;
        at_edge(6);
        chk("t3_press", 32'(press), 32'h084);
        chk("t3_idx", 32'(press_idx), 2);
        at_edge(5);
        raw_button[7] = 1'b0;
        at_edge(6);
        chk("t3_rel", 32'(release_pulse), 32'h080);
        chk("t3_held", 32'(held), 32'h004);

        // async reset mid-count (ch5 cnt=2) and mid-held (ch2)
        raw_button[5] = 1'b1;
        at_edge(4);
        #3 rst_n = 1'b0;
        #1;
        chk("t4_held", 32'(held), 0);
        chk("t4_press", 32'(press), 0);
        chk("t4_rel", 32'(release_pulse), 0);
        chk("t4_any", 32'({any_press, press_idx}), 0);
        at_edge(2);
        @(negedge clk) rst_n = 1'b1;
        at_edge(5);
        chk("t4_early", 32'(press), 0);
        at_edge(1);
        chk("t4_repress", 32'(press), 32'h024);
        chk("t4_idx", 32'(press_idx), 2);

        // single-channel, no-filter instance
        raw1 = 1'b1;
        at_edge(2);
        chk("t5_early", 32'(press1), 0);
        at_edge(1);
        chk("t5_press", 32'({press1, any1, idx1, held1}), 32'b1101);
        raw1 = 1'b0;
        at_edge(3);
        chk("t5_rel", 32'({rel1, press1, held1}), 32'b100);

        // hold channel 4: auto-repeat only when the feature is built
        raw_button[4] = 1'b1;
        at_edge(6);
        chk("t6_press", 32'(press[4]), 1);
        at_edge(50);
        chk("t6_r50", 32'(press[4]), 32'(RPT));
        at_edge(10);
        chk("t6_r60", 32'(press[4]), 32'(RPT));
        at_edge(10);
        chk("t6_r70", 32'(press[4]), 32'(RPT));
        at_edge(4);
        raw_button[4] = 1'b0;
        at_edge(6);
        chk("t6_rel", 32'({release_pulse[4], press[4]}), 32'b10);

        raw_button = '0;
        at_edge(12);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
